// File: rtl/counter_match.sv
// counter_match: compare-match timer fed by a free-running counter.
// It raises a one-cycle match pulse and a sticky irq when the count reaches
// the programmed target. One-shot and periodic modes are supported, and a
// sticky overrun flag reports periodic reloads that are already behind.
// The compare is wrap-aware, so rollover and skipped counts are handled.
module counter_match #(
    parameter int CW  = 32,
    parameter int MCW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [CW-1:0]  cnt_in,
    input  logic           load,
    input  logic [CW-1:0]  delta,
    input  logic           periodic,
    input  logic           stop,
    input  logic           irq_clr,
    output logic           match,
    output logic           irq,
    output logic           busy,
    output logic [CW-1:0]  target,
    output logic [MCW-1:0] match_cnt,
    output logic           overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   period;
    logic            mode;
    logic [CW-1:0]   eff;
    logic [CW-1:0]   next_tgt;
    logic            load_go;
    logic            hit;
    logic            ovr_hit;

    // True when cnt is at or beyond tgt. The wrapped difference is treated as
    // a signed value, so targets just past a rollover still compare
    // correctly, provided they stay within half the count range.
    function automatic logic reached(input logic [CW-1:0] cnt,
                                     input logic [CW-1:0] tgt);
        logic signed [CW-1:0] diff;
        diff = $signed(cnt - tgt);
        return ~diff[CW-1];
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [MCW-1:0] sat_inc(input logic [MCW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A zero interval would be meaningless, so it is treated as one count.
    // A stop pulse overrides a simultaneous load.
    assign eff      = (delta == '0) ? {{(CW-1){1'b0}}, 1'b1} : delta;
    assign next_tgt = target + period;
    assign load_go  = load & ~stop;

    // Next-state and hit detection. A load or stop in a cycle discards any
    // hit in that same cycle.
    always_comb begin
        state_nxt = state;
        hit       = 1'b0;
        ovr_hit   = 1'b0;
        if (state == ARMED && !stop && !load) begin
            hit = reached(cnt_in, target);
        end
        if (hit && mode) begin
            ovr_hit = reached(cnt_in, next_tgt);
        end
        if (stop) begin
            state_nxt = IDLE;
        end else if (load) begin
            state_nxt = ARMED;
        end else if (hit && !mode) begin
            state_nxt = EXPIRED;
        end
    end

    // State register; busy is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ARMED);
        end
    end

    // Arming registers: target, reload period, mode and hit counter.
    // A periodic reload steps from the old target, so it does not drift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target    <= '0;
            period    <= '0;
            mode      <= 1'b0;
            match_cnt <= '0;
        end else if (load_go) begin
            target    <= cnt_in + eff;
            period    <= eff;
            mode      <= periodic;
            match_cnt <= '0;
        end else if (hit) begin
            match_cnt <= sat_inc(match_cnt);
            if (mode) begin
                target <= next_tgt;
            end
        end
    end

    // Status outputs. A hit takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match   <= 1'b0;
            irq     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            match   <= hit;
            irq     <= hit | (irq & ~irq_clr);
            overrun <= ovr_hit | (overrun & ~irq_clr);
        end
    end

endmodule

// File: tb/tb_counter_match.sv
// Directed testbench for counter_match with hand-computed expectations.
module tb_counter_match;

    logic        clk;
    logic        rst_n;
    logic [31:0] cnt_in;
    logic        load;
    logic [31:0] delta;
    logic        periodic;
    logic        stop;
    logic        irq_clr;
    logic        match;
    logic        irq;
    logic        busy;
    logic [31:0] target;
    logic [15:0] match_cnt;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    counter_match #(.CW(32), .MCW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_in    (cnt_in),
        .load      (load),
        .delta     (delta),
        .periodic  (periodic),
        .stop      (stop),
        .irq_clr   (irq_clr),
        .match     (match),
        .irq       (irq),
        .busy      (busy),
        .target    (target),
        .match_cnt (match_cnt),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, got, exp);
        end
    endtask

    // Present a count for one cycle; pulse inputs are cleared afterwards.
    task automatic tick(input logic [31:0] c);
        cnt_in = c;
        @(posedge clk);
        #1;
        load    = 1'b0;
        stop    = 1'b0;
        irq_clr = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        cnt_in   = 32'd0;
        load     = 1'b0;
        delta    = 32'd0;
        periodic = 1'b0;
        stop     = 1'b0;
        irq_clr  = 1'b0;

        // Reset state
        #12;
        chk("rst_match", match, 0);
        chk("rst_irq", irq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_target", target, 0);
        chk("rst_mcnt", match_cnt, 0);
        chk("rst_ovr", overrun, 0);
        rst_n = 1'b1;

        // One-shot: load at 10 with delta 5 -> target 15
        for (int i = 0; i < 10; i++) begin
            tick(i);
            chk("pre_match", match, 0);
        end
        load = 1'b1; delta = 32'd5; periodic = 1'b0;
        tick(32'd10);
        chk("os_target", target, 32'd15);
        chk("os_busy", busy, 1);
        chk("os_mcnt0", match_cnt, 0);
        for (int i = 11; i < 15; i++) begin
            tick(i);
            chk("os_nomatch", match, 0);
        end
        tick(32'd15);
        chk("os_match", match, 1);
        chk("os_irq", irq, 1);
        chk("os_busy_drop", busy, 0);
        chk("os_mcnt1", match_cnt, 1);
        tick(32'd16);
        chk("os_match_pulse", match, 0);
        for (int i = 17; i < 21; i++) begin
            tick(i);
            chk("os_nomore", match, 0);
        end
        chk("os_mcnt_hold", match_cnt, 1);

        // Periodic: load at 100, delta 4
        load = 1'b1; delta = 32'd4; periodic = 1'b1;
        tick(32'd100);
        chk("per_target0", target, 32'd104);
        chk("per_mcnt0", match_cnt, 0);
        for (int i = 101; i < 104; i++) begin
            tick(i);
            chk("per_nomatch1", match, 0);
        end
        tick(32'd104);
        chk("per_match1", match, 1);
        chk("per_target1", target, 32'd108);
        for (int i = 105; i < 108; i++) begin
            tick(i);
            chk("per_nomatch2", match, 0);
        end
        tick(32'd108);
        chk("per_match2", match, 1);
        chk("per_target2", target, 32'd112);
        for (int i = 109; i < 112; i++) tick(i);
        tick(32'd112);
        chk("per_match3", match, 1);
        chk("per_target3", target, 32'd116);
        chk("per_mcnt3", match_cnt, 3);
        chk("per_ovr", overrun, 0);
        chk("per_busy", busy, 1);
        for (int i = 113; i < 116; i++) tick(i);

        // irq_clr together with a hit: set wins
        irq_clr = 1'b1;
        tick(32'd116);
        chk("clr_hit_match", match, 1);
        chk("clr_hit_irq", irq, 1);
        irq_clr = 1'b1;
        tick(32'd117);
        chk("clr_alone_irq", irq, 0);

        // stop + load while armed: stop wins
        stop = 1'b1; load = 1'b1; delta = 32'd1; periodic = 1'b0;
        tick(32'd118);
        chk("sl_busy", busy, 0);
        chk("sl_match", match, 0);
        chk("sl_target", target, 32'd120);
        chk("sl_mcnt", match_cnt, 4);
        for (int i = 119; i < 125; i++) begin
            tick(i);
            chk("sl_nomatch", match, 0);
        end

        // Wrap: load at 0xFFFFFFFD, delta 6 -> target 3
        load = 1'b1; delta = 32'd6; periodic = 1'b0;
        tick(32'hFFFF_FFFD);
        chk("wr_target", target, 32'd3);
        tick(32'hFFFF_FFFE);
        chk("wr_no_fffe", match, 0);
        tick(32'hFFFF_FFFF);
        chk("wr_no_ffff", match, 0);
        for (int i = 0; i < 3; i++) begin
            tick(i);
            chk("wr_no_low", match, 0);
        end
        tick(32'd3);
        chk("wr_match", match, 1);
        chk("wr_mcnt", match_cnt, 1);
        chk("wr_busy", busy, 0);

        // Wrap with a skipped count: 2 -> 5 still fires
        load = 1'b1;
        tick(32'hFFFF_FFFD);
        chk("sk_busy", busy, 1);
        tick(32'hFFFF_FFFE);
        tick(32'hFFFF_FFFF);
        tick(32'd0);
        tick(32'd1);
        tick(32'd2);
        chk("sk_no2", match, 0);
        tick(32'd5);
        chk("sk_match5", match, 1);

        // Overrun: delta 1 while the counter advances by 3 per cycle
        load = 1'b1; delta = 32'd1; periodic = 1'b1;
        tick(32'd1000);
        chk("ov_target0", target, 32'd1001);
        chk("ov_ovr0", overrun, 0);
        tick(32'd1003);
        chk("ov_match1", match, 1);
        chk("ov_ovr1", overrun, 1);
        chk("ov_target1", target, 32'd1002);
        tick(32'd1006);
        chk("ov_match2", match, 1);
        chk("ov_target2", target, 32'd1003);
        tick(32'd1009);
        chk("ov_match3", match, 1);
        chk("ov_mcnt3", match_cnt, 3);
        stop = 1'b1;
        tick(32'd1012);
        chk("ov_stop_match", match, 0);
        chk("ov_stop_busy", busy, 0);
        chk("ov_stop_ovr", overrun, 1);
        irq_clr = 1'b1;
        tick(32'd1015);
        chk("ov_clr_ovr", overrun, 0);
        chk("ov_clr_irq", irq, 0);

        // Async reset one cycle before the target
        load = 1'b1; delta = 32'd3; periodic = 1'b0;
        tick(32'd2000);
        chk("ar_target", target, 32'd2003);
        chk("ar_busy", busy, 1);
        tick(32'd2001);
        cnt_in = 32'd2002;
        #1 rst_n = 1'b0;
        #1;
        chk("ar_target0", target, 0);
        chk("ar_busy0", busy, 0);
        chk("ar_match0", match, 0);
        chk("ar_irq0", irq, 0);
        chk("ar_mcnt0", match_cnt, 0);
        chk("ar_ovr0", overrun, 0);
        #1 rst_n = 1'b1;
        for (int i = 2002; i < 2006; i++) begin
            tick(i);
            chk("ar_nomatch", match, 0);
            chk("ar_nobusy", busy, 0);
        end

        // delta 0 behaves as delta 1
        load = 1'b1; delta = 32'd0; periodic = 1'b0;
        tick(32'd3000);
        chk("d0_target", target, 32'd3001);
        chk("d0_busy", busy, 1);
        tick(32'd3001);
        chk("d0_match", match, 1);
        chk("d0_mcnt", match_cnt, 1);
        tick(32'd3002);
        chk("d0_pulse", match, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_match.md
Name: counter_match

Overview:
- Compare-match timer directly downstream of the free-running 32-bit `counter`.
- Consumes the counter's count value and raises a one-cycle `match` pulse and a sticky `irq` when the count reaches a programmed target.
- Supports one-shot and periodic modes, with overrun detection for periods the consumer cannot keep up with.
- Comparisons are wrap-aware, so the block works across the 0xFFFFFFFF→0 rollover and when the counter skips values.

Parameters:
- CW, 32, width of `cnt_in`, `delta` and `target`.
- MCW, 16, width of the saturating match counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cnt_in  input  CW  count value from the upstream counter, sampled every cycle.
- load  input  1  one-cycle pulse: arm the timer with target = cnt_in + delta.
- delta  input  CW  interval to the first match; also the reload period in periodic mode; sampled on `load`.
- periodic  input  1  sampled on `load`: 1 = periodic, 0 = one-shot.
- stop  input  1  one-cycle pulse: disarm, go to IDLE.
- irq_clr  input  1  clears `irq` and `overrun`.
- match  output  1  one-cycle pulse per hit.
- irq  output  1  sticky interrupt, set on every hit.
- busy  output  1  high while in ARMED.
- target  output  CW  current target register.
- match_cnt  output  MCW  number of hits since the last `load`, saturating.
- overrun  output  1  sticky; next periodic target already passed at reload time.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - match=0, irq=0, busy=0, target=0, match_cnt=0, overrun=0.
  - Internal period register = 0, mode = one-shot.
  - Reset mid-operation aborts any armed timer immediately; no match is issued afterwards until a new `load`.
- States:
  - IDLE: disarmed.
  - ARMED: comparing.
  - EXPIRED: one-shot fired; behaves as IDLE, but the fire remains visible via irq/match_cnt.
- `load` in any state:
  - eff = (delta==0) ? 1 : delta.
  - target <= cnt_in + eff, mod 2^CW.
  - period <= eff; mode <= periodic; match_cnt <= 0; state <= ARMED.
  - irq and overrun are not touched.
  - No hit is evaluated in the load cycle.
- Hit condition, evaluated in ARMED only: the signed CW-bit difference (cnt_in - target) is ≥ 0.
  - This tolerates skipped counts and wrap.
  - The target must stay within 2^(CW-1) of the count.
- Hit in cycle N:
  - match=1 in cycle N+1 only.
  - irq=1 from cycle N+1.
  - match_cnt increments, holding at all-ones.
- Periodic hit:
  - target <= target + period. The new target is derived from the old target, not from cnt_in, so there is no drift.
  - If (cnt_in - (target + period)) signed ≥ 0, then overrun <= 1. The next hit then occurs on the following cycle.
- One-shot hit: state <= EXPIRED; busy drops in cycle N+1.
- `stop`: state <= IDLE from the next cycle. A hit in that same cycle is suppressed.
- Simultaneous events:
  - stop + load: stop wins.
  - irq_clr + hit in the same cycle: irq stays 1 (set wins); overrun follows the same rule.
  - load while ARMED: re-arms with the new target; a pending hit in that cycle is discarded.
- Outputs `target` and `busy` are registered. `busy` = (state==ARMED).
- Latency from cnt_in reaching the target to `match`: exactly 1 cycle.

Test Plan:
- Reset release with the counter running from 0; load at cnt_in=10 with delta=5, periodic=0 → target=15; match high for exactly one cycle when cnt_in=16 is presented (one cycle after 15); busy drops and irq=1; match_cnt=1; no further matches.
- Periodic: load at cnt_in=100 with delta=4 → matches in the cycles after cnt_in=104, 108 and 112; target steps 104→108→112→116; match_cnt=3 after 3 hits; overrun stays 0.
- Wrap: load at cnt_in=0xFFFFFFFD with delta=6 → target=0x00000003; match after cnt_in=3 and not at 0xFFFFFFFE or 0xFFFFFFFF; skipped count (cnt_in jumps 2→5) still fires on 5.
- Simultaneous events:
  - irq_clr asserted in the same cycle as a hit → irq remains 1.
  - irq_clr alone later → irq=0.
  - stop+load together while ARMED → IDLE, busy=0, no match.
- Overrun: load periodic with delta=1 while cnt_in advances by 3 per cycle → overrun=1 after the first hit; match high on consecutive cycles; irq_clr clears overrun.
- Async reset pulse while ARMED one cycle before the target → all outputs 0 immediately; no match after rst_n returns high; delta=0 load → behaves as delta=1.
